// File: rtl/quad_dec_pkg.sv
// Shared definitions for the quadrature decoder: register map, bit positions,
// reset constants and the Gray-code step classifier.
package quad_dec_pkg;

    localparam logic [1:0] ADDR_COUNT   = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_ID      = 2'd3;

    localparam int STATUS_DIR_BIT = 0;
    localparam int STATUS_ERR_BIT = 1;
    localparam int STATUS_IDX_BIT = 2;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_INV_BIT     = 1;
    localparam int CTRL_CLR_IDX_BIT = 2;

    localparam logic [2:0]  CTRL_RESET       = 3'b001;
    localparam logic [2:0]  STATUS_RESET     = 3'b000;
    localparam logic [31:0] DEFAULT_BLOCK_ID = 32'h5AFE_0001;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    // Position of an {A,B} pair along the forward Gray cycle 00,01,11,10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            2'b10:   pos = 2'd3;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

    // A distance of 2 along the cycle means both channels moved at once.
    function automatic step_e classify_step(input logic [1:0] prev_ab,
                                            input logic [1:0] cur_ab);
        logic [1:0] delta;
        step_e      step;
        delta = gray_pos(cur_ab) - gray_pos(prev_ab);
        case (delta)
            2'd0:    step = STEP_NONE;
            2'd1:    step = STEP_FWD;
            2'd3:    step = STEP_REV;
            default: step = STEP_ILLEGAL;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/quad_dec_filter.sv
// Two-flop synchroniser followed by a stable-count glitch filter: the output
// follows the synchronised input only after FILTER_LEN equal samples.
module quad_dec_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam int                 CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             filt_r;
    logic [CNT_W-1:0] stable_cnt_r;

    // Synchroniser chain for the asynchronous encoder pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Counts consecutive samples that disagree with the filtered value; any
    // agreeing sample restarts the count, so short glitches never propagate.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_r       <= 1'b0;
            stable_cnt_r <= CNT_ZERO;
        end else if (sync2_r == filt_r) begin
            stable_cnt_r <= CNT_ZERO;
        end else if (stable_cnt_r == CNT_LAST) begin
            filt_r       <= sync2_r;
            stable_cnt_r <= CNT_ZERO;
        end else begin
            stable_cnt_r <= stable_cnt_r + CNT_ONE;
        end
    end

    assign filt = filt_r;

endmodule

// File: rtl/quad_dec_counter.sv
// Avalon-MM quadrature decoder: filtered A/B/index inputs, 4x decode into a
// signed position counter, sticky status flags and a four-word register map.
module quad_dec_counter
    import quad_dec_pkg::*;
#(
    parameter int          COUNT_W    = 32,
    parameter int          FILTER_LEN = 4,
    parameter logic [31:0] BLOCK_ID   = DEFAULT_BLOCK_ID
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_i
);

    localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    logic               filt_a_s;
    logic               filt_b_s;
    logic               filt_i_s;
    logic [1:0]         cur_ab_s;
    step_e              step_s;
    logic               step_valid_s;
    logic               step_up_s;
    logic               illegal_s;
    logic               idx_rise_s;
    logic               wr_count_s;
    logic               wr_status_s;
    logic               wr_ctrl_s;
    logic [COUNT_W-1:0] count_nxt_s;
    logic               dir_nxt_s;
    logic [2:0]         status_nxt_s;
    logic [2:0]         ctrl_nxt_s;
    logic [31:0]        rd_mux_s;

    logic [1:0]         prev_ab_r;
    logic               prev_i_r;
    logic [COUNT_W-1:0] count_r;
    logic [2:0]         status_r;
    logic [2:0]         ctrl_r;
    logic [31:0]        readdata_r;

    quad_dec_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clock (clock),
        .reset (reset),
        .raw   (enc_a),
        .filt  (filt_a_s)
    );

    quad_dec_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clock (clock),
        .reset (reset),
        .raw   (enc_b),
        .filt  (filt_b_s)
    );

    quad_dec_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
        .clock (clock),
        .reset (reset),
        .raw   (enc_i),
        .filt  (filt_i_s)
    );

    assign cur_ab_s   = {filt_a_s, filt_b_s};
    assign step_s     = classify_step(prev_ab_r, cur_ab_s);
    assign illegal_s  = (step_s == STEP_ILLEGAL);
    assign idx_rise_s = filt_i_s & ~prev_i_r;

    // Bus write strobes per register.
    always_comb begin
        wr_count_s  = 1'b0;
        wr_status_s = 1'b0;
        wr_ctrl_s   = 1'b0;
        if (write) begin
            wr_count_s  = (address == ADDR_COUNT);
            wr_status_s = (address == ADDR_STATUS);
            wr_ctrl_s   = (address == ADDR_CONTROL);
        end else begin
            wr_count_s  = 1'b0;
            wr_status_s = 1'b0;
            wr_ctrl_s   = 1'b0;
        end
    end

    // Step direction after optional inversion.
    always_comb begin
        step_valid_s = 1'b0;
        step_up_s    = 1'b0;
        case (step_s)
            STEP_FWD: begin
                step_valid_s = 1'b1;
                step_up_s    = ~ctrl_r[CTRL_INV_BIT];
            end
            STEP_REV: begin
                step_valid_s = 1'b1;
                step_up_s    = ctrl_r[CTRL_INV_BIT];
            end
            default: begin
                step_valid_s = 1'b0;
                step_up_s    = 1'b0;
            end
        endcase
    end

    // Counter priority: host write, then index clear, then an enabled step.
    always_comb begin
        count_nxt_s = count_r;
        dir_nxt_s   = status_r[STATUS_DIR_BIT];
        if (wr_count_s) begin
            count_nxt_s = writedata[COUNT_W-1:0];
        end else if (idx_rise_s && ctrl_r[CTRL_CLR_IDX_BIT]) begin
            count_nxt_s = COUNT_ZERO;
        end else if (step_valid_s && ctrl_r[CTRL_EN_BIT]) begin
            count_nxt_s = step_up_s ? (count_r + COUNT_ONE) : (count_r - COUNT_ONE);
            dir_nxt_s   = step_up_s;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Sticky flags: a set event in the same cycle as a W1C keeps the bit high.
    always_comb begin
        status_nxt_s                 = status_r;
        status_nxt_s[STATUS_DIR_BIT] = dir_nxt_s;
        status_nxt_s[STATUS_ERR_BIT] = (status_r[STATUS_ERR_BIT]
                                        & ~(wr_status_s & writedata[STATUS_ERR_BIT]))
                                       | illegal_s;
        status_nxt_s[STATUS_IDX_BIT] = (status_r[STATUS_IDX_BIT]
                                        & ~(wr_status_s & writedata[STATUS_IDX_BIT]))
                                       | idx_rise_s;
    end

    // Control register keeps only its three defined bits.
    always_comb begin
        ctrl_nxt_s = ctrl_r;
        if (wr_ctrl_s) begin
            ctrl_nxt_s = writedata[2:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
    end

    // Read mux over current (pre-write) register contents.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (address)
            ADDR_COUNT:   rd_mux_s = 32'($signed(count_r));
            ADDR_STATUS:  rd_mux_s = {29'd0, status_r};
            ADDR_CONTROL: rd_mux_s = {29'd0, ctrl_r};
            ADDR_ID:      rd_mux_s = BLOCK_ID;
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Decoder history, counter, status and control state.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_ab_r <= 2'b00;
            prev_i_r  <= 1'b0;
            count_r   <= COUNT_ZERO;
            status_r  <= STATUS_RESET;
            ctrl_r    <= CTRL_RESET;
        end else begin
            prev_ab_r <= cur_ab_s;
            prev_i_r  <= filt_i_s;
            count_r   <= count_nxt_s;
            status_r  <= status_nxt_s;
            ctrl_r    <= ctrl_nxt_s;
        end
    end

    // Read data register holds its value until the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_r <= 32'h0000_0000;
        end else if (read) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    assign readdata = readdata_r;

endmodule

// File: tb/tb_quad_dec_counter.sv
// Self-checking bench for quad_dec_counter: register table, directed corner
// sequences and a randomized run against a position-level reference model.
module tb_quad_dec_counter;
    import quad_dec_pkg::*;

    localparam int FL = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] readdata16;
    logic        enc_a;
    logic        enc_b;
    logic        enc_i;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    quad_dec_counter #(.COUNT_W(32), .FILTER_LEN(FL)) dut (
        .clock (clock), .reset (reset), .address (address), .read (read),
        .write (write), .writedata (writedata), .readdata (readdata),
        .enc_a (enc_a), .enc_b (enc_b), .enc_i (enc_i)
    );

    quad_dec_counter #(.COUNT_W(16), .FILTER_LEN(FL)) dut16 (
        .clock (clock), .reset (reset), .address (address), .read (read),
        .write (write), .writedata (writedata), .readdata (readdata16),
        .enc_a (enc_a), .enc_b (enc_b), .enc_i (enc_i)
    );

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic set_ab(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic rotate(input int turns, input bit fwd);
        for (int t = 0; t < turns; t++) begin
            for (int k = 1; k <= 4; k++) begin
                set_ab(fwd ? seq[k % 4] : seq[(4 - k) % 4]);
                hold(10);
            end
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] d;
        int          bad;
        int          seen;
        int          pos;
        logic [31:0] m_count;
        logic        m_dir, m_err, m_en, m_inv;

        reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0;
        writedata = 32'h0; enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;
        hold(3);
        reset = 1'b0;
        check("reset_readdata", readdata, 32'h0000_0000);

        // Register-level table: optional write, then read back.
        vecs.push_back('{ADDR_ID,      1'b0, 32'h0000_0000, 32'h5AFE_0001});
        vecs.push_back('{ADDR_CONTROL, 1'b0, 32'h0000_0000, 32'h0000_0001});
        vecs.push_back('{ADDR_STATUS,  1'b0, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{ADDR_COUNT,   1'b0, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{ADDR_ID,      1'b1, 32'hFFFF_FFFF, 32'h5AFE_0001});
        vecs.push_back('{ADDR_CONTROL, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000});
        vecs.push_back('{ADDR_CONTROL, 1'b1, 32'h0000_0006, 32'h0000_0006});
        vecs.push_back('{ADDR_CONTROL, 1'b1, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{ADDR_COUNT,   1'b1, 32'h1234_5678, 32'h1234_5678});
        vecs.push_back('{ADDR_COUNT,   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{ADDR_STATUS,  1'b1, 32'h0000_0007, 32'h0000_0000});
        vecs.push_back('{ADDR_COUNT,   1'b1, 32'h0000_0000, 32'h0000_0000});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            check_reg($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Simultaneous read and write returns the old value.
        address = ADDR_COUNT; writedata = 32'd77; read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        check("rw_same_cycle_old", readdata, 32'h0000_0000);
        check_reg("rw_same_cycle_new", ADDR_COUNT, 32'd77);
        bus_write(ADDR_COUNT, 32'd0);

        // Forward three turns, reverse two.
        rotate(3, 1'b1);
        check_reg("fwd_count", ADDR_COUNT, 32'd12);
        check_reg("fwd_status", ADDR_STATUS, 32'h1);
        rotate(2, 1'b0);
        check_reg("rev_count", ADDR_COUNT, 32'd4);
        check_reg("rev_status", ADDR_STATUS, 32'h0);

        // Edge-to-count latency of 2 + FL + 1 clocks.
        address = ADDR_COUNT; read = 1'b1;
        set_ab(2'b01);
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 7) check("latency_before", readdata, 32'd4);
            if (n == 8) check("latency_after", readdata, 32'd5);
        end
        read = 1'b0;
        set_ab(2'b00);
        hold(10);

        // Illegal 00 -> 11, then W1C clear.
        set_ab(2'b11);
        hold(10);
        check_reg("illegal_count", ADDR_COUNT, 32'd4);
        check_reg("illegal_status", ADDR_STATUS, 32'h2);
        bus_write(ADDR_STATUS, 32'h2);
        check_reg("err_w1c", ADDR_STATUS, 32'h0);
        set_ab(2'b10); hold(10);
        set_ab(2'b00); hold(10);
        check_reg("back_count", ADDR_COUNT, 32'd6);

        // W1C in the same cycle as an illegal transition: set wins.
        set_ab(2'b11);
        hold(6);
        bus_write(ADDR_STATUS, 32'h2);
        hold(3);
        check_reg("err_set_wins", ADDR_STATUS, 32'h3);
        bus_write(ADDR_STATUS, 32'h2);
        set_ab(2'b10); hold(10);
        set_ab(2'b00); hold(10);
        check_reg("post_collide", ADDR_COUNT, 32'd8);

        // Glitch shorter than the filter length is dropped.
        address = ADDR_COUNT; read = 1'b1; bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) enc_a = 1'b1;
            if (i == 3) enc_a = 1'b0;
            tick();
            if (readdata !== 32'd8) bad++;
        end
        read = 1'b0;
        check("glitch3_changes", bad, 0);
        check_reg("glitch3_status", ADDR_STATUS, 32'h1);

        // A 5-clock pulse passes: one step away and one step back.
        address = ADDR_COUNT; read = 1'b1; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) enc_a = 1'b1;
            if (i == 5) enc_a = 1'b0;
            tick();
            if (readdata === 32'd7) seen++;
        end
        read = 1'b0;
        check("glitch5_counted", (seen > 0) ? 32'd1 : 32'd0, 32'd1);
        check_reg("glitch5_count", ADDR_COUNT, 32'd8);
        check_reg("glitch5_status", ADDR_STATUS, 32'h1);

        // Wrap on both counter widths.
        bus_write(ADDR_COUNT, 32'h7FFF_FFFF);
        bus_read(ADDR_COUNT, d);
        check("w16_sign_ext", readdata16, 32'hFFFF_FFFF);
        set_ab(2'b01); hold(10);
        bus_read(ADDR_COUNT, d);
        check("wrap32", d, 32'h8000_0000);
        check("wrap16", readdata16, 32'h0000_0000);

        // Index clear beats a simultaneous step.
        bus_write(ADDR_CONTROL, 32'h5);
        bus_write(ADDR_COUNT, 32'd50);
        set_ab(2'b11); enc_i = 1'b1;
        hold(10);
        check_reg("idx_clear_count", ADDR_COUNT, 32'd0);
        check_reg("idx_status", ADDR_STATUS, 32'h5);
        enc_i = 1'b0; hold(10);
        set_ab(2'b10); hold(10);
        check_reg("idx_after_step", ADDR_COUNT, 32'd1);

        // Host write beats a step landing in the same cycle.
        set_ab(2'b00);
        hold(6);
        bus_write(ADDR_COUNT, 32'd100);
        hold(5);
        check_reg("write_beats_step", ADDR_COUNT, 32'd100);
        bus_write(ADDR_STATUS, 32'h4);
        check_reg("idx_w1c", ADDR_STATUS, 32'h1);
        bus_write(ADDR_CONTROL, 32'h1);

        // Reset in the middle of rotation.
        check_reg("id_before_reset", ADDR_ID, 32'h5AFE_0001);
        set_ab(2'b01); hold(3);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_reset_readdata", readdata, 32'h0000_0000);
        check_reg("mid_reset_count", ADDR_COUNT, 32'd0);
        check_reg("mid_reset_ctrl", ADDR_CONTROL, 32'h1);
        check_reg("mid_reset_id", ADDR_ID, 32'h5AFE_0001);
        hold(10);
        check_reg("first_decode_after_reset", ADDR_COUNT, 32'd1);

        // Randomized moves against a position-level model.
        set_ab(2'b00);
        reset = 1'b1; tick(); reset = 1'b0;
        hold(10);
        pos = 0; m_count = 32'd0; m_dir = 1'b0; m_err = 1'b0; m_en = 1'b1; m_inv = 1'b0;
        for (int it = 0; it < 60; it++) begin
            int  r;
            bit  up;
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                up  = (r <= 3);
                pos = up ? (pos + 1) % 4 : (pos + 3) % 4;
                set_ab(seq[pos]);
                if (m_en) begin
                    m_dir   = up ^ m_inv;
                    m_count = m_dir ? m_count + 32'd1 : m_count - 32'd1;
                end
            end else if (r == 7) begin
                pos = (pos + 2) % 4;
                set_ab(seq[pos]);
                m_err = 1'b1;
            end else if (r == 8) begin
                logic [1:0] g;
                g = seq[pos] ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
                set_ab(g);
                hold($urandom_range(1, FL - 1));
                set_ab(seq[pos]);
            end else begin
                logic [1:0] c;
                c = 2'($urandom_range(0, 3));
                bus_write(ADDR_CONTROL, {30'd0, c});
                m_en = c[0]; m_inv = c[1];
                if ($urandom_range(0, 1) == 1) begin
                    bus_write(ADDR_STATUS, 32'h2);
                    m_err = 1'b0;
                end
            end
            hold(FL + 4);
            check_reg($sformatf("rand%0d_count", it), ADDR_COUNT, m_count);
            check_reg($sformatf("rand%0d_status", it), ADDR_STATUS, {29'd0, 1'b0, m_err, m_dir});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
